// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/forwarding scoreboard: slot record, forward-select
// encodings and the common source-match helper.
package hazard_scoreboard_pkg;

  // Slot addresses are stored at a fixed width wide enough for any REG_AW used (<= 8).
  localparam int SB_AW = 8;
  typedef logic [SB_AW-1:0] sb_addr_t;

  localparam sb_addr_t REG_ZERO = '0;

  typedef enum logic [2:0] {
    FWD_IDEX = 3'd0,
    FWD_S1   = 3'd1,
    FWD_S2   = 3'd2,
    FWD_S3   = 3'd3,
    FWD_S4   = 3'd4,
    FWD_S5   = 3'd5
  } fwd_sel_e;

  typedef struct packed {
    logic     valid;
    logic     wr_en;
    sb_addr_t wr_addr;
    logic     is_load;
    sb_addr_t rs;
    sb_addr_t rt;
    logic     use_rs;
    logic     use_rt;
  } slot_t;

  function automatic logic src_match(input slot_t s, input logic use_src, input sb_addr_t src);
    return s.valid && s.wr_en && use_src && (src != REG_ZERO) && (src == s.wr_addr);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the ID stage: a shift-register scoreboard of
// in-flight writes drives stall, flush, EX forward selects and ID bypass.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int BR_SLOT = 1,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush,
  output logic [2:0]        fwd_a,
  output logic [2:0]        fwd_b,
  output logic              byp_a,
  output logic              byp_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  slot_t    slot_q [DEPTH];
  slot_t    slot_d [DEPTH];
  sb_addr_t id_rs_x, id_rt_x;
  logic     raw_hazard;
  fwd_sel_e fwd_a_sel, fwd_b_sel;

  assign id_rs_x = sb_addr_t'(id_rs);
  assign id_rt_x = sb_addr_t'(id_rt);

  always_comb begin
    flush      = br_taken && slot_q[BR_SLOT].valid;
    raw_hazard = 1'b0;
    if (FWD_EN) begin
      // Only a load still in EX cannot be forwarded in time.
      raw_hazard = slot_q[0].is_load &&
                   (src_match(slot_q[0], id_use_rs, id_rs_x) ||
                    src_match(slot_q[0], id_use_rt, id_rt_x));
    end else begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (src_match(slot_q[k], id_use_rs, id_rs_x) ||
            src_match(slot_q[k], id_use_rt, id_rt_x)) raw_hazard = 1'b1;
      end
    end
    stall = raw_hazard && !flush;
  end

  always_comb begin
    fwd_a_sel = FWD_IDEX;
    fwd_b_sel = FWD_IDEX;
    if (FWD_EN) begin
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (!slot_q[k].is_load || k >= 2) begin
          if (src_match(slot_q[k], slot_q[0].use_rs, slot_q[0].rs)) fwd_a_sel = fwd_sel_e'(3'(k));
          if (src_match(slot_q[k], slot_q[0].use_rt, slot_q[0].rt)) fwd_b_sel = fwd_sel_e'(3'(k));
        end
      end
    end
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;
  assign byp_a = src_match(slot_q[DEPTH-1], id_use_rs, id_rs_x);
  assign byp_b = src_match(slot_q[DEPTH-1], id_use_rt, id_rt_x);

  always_comb begin
    slot_d[0] = '0;
    if (id_valid && !stall && !flush) begin
      slot_d[0].valid   = 1'b1;
      slot_d[0].wr_en   = id_wr_en;
      slot_d[0].wr_addr = sb_addr_t'(id_wr_addr);
      slot_d[0].is_load = id_is_load;
      slot_d[0].rs      = id_rs_x;
      slot_d[0].rt      = id_rt_x;
      slot_d[0].use_rs  = id_use_rs;
      slot_d[0].use_rt  = id_use_rt;
    end
    for (int k = 1; k < DEPTH; k++) slot_d[k] = slot_q[k-1];
    if (flush) begin
      for (int k = 0; k < BR_SLOT; k++) slot_d[k] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (stall),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: one forwarding instance and one
// non-forwarding instance with 2-bit counters, sharing the ID-side stimulus.
module tb_hazard_scoreboard;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, br_taken;
  logic [AW-1:0] id_rs, id_rt, id_wr_addr;

  logic          a_stall, a_flush, a_byp_a, a_byp_b;
  logic [2:0]    a_fwd_a, a_fwd_b;
  logic [15:0]   a_stall_cnt, a_flush_cnt;
  logic          b_stall, b_flush, b_byp_a, b_byp_b;
  logic [2:0]    b_fwd_a, b_fwd_b;
  logic [1:0]    b_stall_cnt, b_flush_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(3), .BR_SLOT(1), .FWD_EN(1'b1), .CNT_W(16)) u_a (
    .CLK(clk), .RST(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(a_stall), .flush(a_flush), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .byp_a(a_byp_a), .byp_b(a_byp_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(3), .BR_SLOT(1), .FWD_EN(1'b0), .CNT_W(2)) u_b (
    .CLK(clk), .RST(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(b_stall), .flush(b_flush), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .byp_a(b_byp_a), .byp_b(b_byp_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; bit we; int wa; bit ld;
  } ins_t;

  typedef struct {
    string tag; bit dut_b;
    logic stall; logic flush; logic [2:0] fwd_a; logic [2:0] fwd_b;
    logic byp_a; logic byp_b; int unsigned scnt; int unsigned fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t nop();
    ins_t i = '{v:0, rs:0, rt:0, urs:0, urt:0, we:0, wa:0, ld:0};
    return i;
  endfunction

  function automatic ins_t alu(input int rd, input int rs, input int rt);
    ins_t i = '{v:1, rs:rs, rt:rt, urs:1, urt:1, we:1, wa:rd, ld:0};
    return i;
  endfunction

  function automatic ins_t lw(input int rd, input int rs);
    ins_t i = '{v:1, rs:rs, rt:rd, urs:1, urt:0, we:1, wa:rd, ld:1};
    return i;
  endfunction

  function automatic ins_t beq(input int rs, input int rt);
    ins_t i = '{v:1, rs:rs, rt:rt, urs:1, urt:1, we:0, wa:0, ld:0};
    return i;
  endfunction

  function automatic exp_t mk(input string tag, input bit b, input logic st, input logic fl,
                              input logic [2:0] fa, input logic [2:0] fb, input logic ba,
                              input logic bb, input int unsigned sc, input int unsigned fc);
    exp_t e = '{tag:tag, dut_b:b, stall:st, flush:fl, fwd_a:fa, fwd_b:fb,
                byp_a:ba, byp_b:bb, scnt:sc, fcnt:fc};
    return e;
  endfunction

  task automatic apply(input ins_t i, input bit br);
    id_valid   = i.v;
    id_rs      = AW'(i.rs);
    id_rt      = AW'(i.rt);
    id_use_rs  = i.urs;
    id_use_rt  = i.urt;
    id_wr_en   = i.we;
    id_wr_addr = AW'(i.wa);
    id_is_load = i.ld;
    br_taken   = br;
  endtask

  task automatic compare_front();
    exp_t e = exp_q.pop_front();
    if (e.dut_b) begin
      check({e.tag, "/stall"}, b_stall, e.stall);
      check({e.tag, "/flush"}, b_flush, e.flush);
      check({e.tag, "/fwd_a"}, b_fwd_a, e.fwd_a);
      check({e.tag, "/fwd_b"}, b_fwd_b, e.fwd_b);
      check({e.tag, "/byp_a"}, b_byp_a, e.byp_a);
      check({e.tag, "/byp_b"}, b_byp_b, e.byp_b);
      check({e.tag, "/stall_cnt"}, b_stall_cnt, e.scnt);
      check({e.tag, "/flush_cnt"}, b_flush_cnt, e.fcnt);
    end else begin
      check({e.tag, "/stall"}, a_stall, e.stall);
      check({e.tag, "/flush"}, a_flush, e.flush);
      check({e.tag, "/fwd_a"}, a_fwd_a, e.fwd_a);
      check({e.tag, "/fwd_b"}, a_fwd_b, e.fwd_b);
      check({e.tag, "/byp_a"}, a_byp_a, e.byp_a);
      check({e.tag, "/byp_b"}, a_byp_b, e.byp_b);
      check({e.tag, "/stall_cnt"}, a_stall_cnt, e.scnt);
      check({e.tag, "/flush_cnt"}, a_flush_cnt, e.fcnt);
    end
  endtask

  // One ID cycle: drive just after the edge, sample combinational outputs mid-cycle.
  task automatic step(input ins_t i, input bit br, input exp_t e);
    @(posedge clk);
    #1;
    apply(i, br);
    exp_q.push_back(e);
    @(negedge clk);
    compare_front();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(nop(), 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    apply(alu(3, 3, 3), 1'b0);
    #1;
    exp_q.push_back(mk("rst_a", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    compare_front();
    exp_q.push_back(mk("rst_b", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    compare_front();
    do_reset();

    // ALU result forwarded from MEM, no stall
    step(alu(3, 1, 2), 0, mk("alu_prod", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(alu(4, 3, 6), 0, mk("alu_cons", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(nop(),        0, mk("alu_fwd",  0, 0, 0, 1, 0, 0, 0, 0, 0));
    step(nop(),        0, mk("alu_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // load-use: one stall, then forward from WB slot
    step(lw(5, 1),     0, mk("lu_load",  0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(alu(6, 2, 5), 0, mk("lu_stall", 0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(alu(6, 2, 5), 0, mk("lu_go",    0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(nop(),        0, mk("lu_fwd",   0, 0, 0, 0, 2, 0, 0, 1, 0));

    // taken branch in MEM while ID has a load-use hazard: flush beats stall
    step(beq(1, 2),    0, mk("br_ins",   0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(lw(9, 3),     0, mk("br_load",  0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(lw(10, 9),    1, mk("br_flush", 0, 0, 1, 0, 0, 0, 0, 1, 0));
    step(alu(11, 10, 0), 0, mk("br_after", 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(nop(),        0, mk("br_idle",  0, 0, 0, 0, 0, 0, 0, 1, 1));

    // two writers of $7 in flight: youngest wins
    step(alu(7, 1, 2),  0, mk("y_w1",   0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(alu(7, 1, 2),  0, mk("y_w2",   0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(alu(12, 7, 7), 0, mk("y_rd",   0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(nop(),         0, mk("y_fwd",  0, 0, 0, 1, 1, 0, 0, 1, 1));

    // asynchronous reset mid-stream with a bypassable read in ID
    #1;
    apply(alu(13, 7, 7), 1'b0);
    rst = 1'b0;
    #1;
    exp_q.push_back(mk("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    compare_front();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(nop(), 1'b0);

    // writes to $0 never hazard, forward or bypass
    step(alu(0, 1, 2), 0, mk("z_w1",  0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(alu(0, 1, 2), 0, mk("z_w2",  0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(lw(0, 1),     0, mk("z_ld",  0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(alu(8, 0, 0), 0, mk("z_rd",  0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(nop(),        0, mk("z_fwd", 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // no forwarding: stall through EX and MEM, then WB bypass; 2-bit counter saturates
    do_reset();
    step(lw(5, 1),     0, mk("nf_load",   1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(alu(6, 2, 5), 0, mk("nf_st1",    1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(alu(6, 2, 5), 0, mk("nf_st2",    1, 1, 0, 0, 0, 0, 0, 1, 0));
    step(alu(6, 2, 5), 0, mk("nf_byp",    1, 0, 0, 0, 0, 0, 1, 2, 0));
    step(alu(8, 6, 0), 0, mk("nf_st3",    1, 1, 0, 0, 0, 0, 0, 2, 0));
    step(alu(8, 6, 0), 0, mk("nf_sat",    1, 1, 0, 0, 0, 0, 0, 3, 0));
    step(alu(8, 6, 0), 0, mk("nf_byp_a",  1, 0, 0, 0, 0, 1, 0, 3, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
